// File: rtl/dac_spi_tx.sv
// SPI mode-0 serializer feeding the board DAC from the sine generator.
// One sample per frame, MSB first; samples arriving mid-frame are dropped and counted.
//
// state | meaning
// IDLE  | waiting for sample_valid, sample_ready high
// LEAD  | dac_cs_n low, dac_sclk low, first bit set up on dac_mosi
// SHIFT | dac_sclk toggling, DATA_W full periods, data moves on falling edges
// TRAIL | dac_sclk low, dac_cs_n still low, last bit held
// GAP   | dac_cs_n high for CS_IDLE cycles before the next accept

module dac_spi_tx #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 4,
  parameter int CS_IDLE    = 2,
  parameter int MSB_INVERT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              busy,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_mosi,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [7:0]        drop_count
);

  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int HALF_W  = $clog2(2 * DATA_W);

  localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(CS_IDLE - 1);
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(2 * DATA_W - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [DATA_W-1:0] MSB_MASK  =
    (MSB_INVERT != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [HALF_W-1:0] half;
  logic [DATA_W-1:0] shreg;
  logic              drop;

  assign drop = sample_valid && (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      half         <= '0;
      shreg        <= '0;
      sample_ready <= 1'b1;
      busy         <= 1'b0;
      dac_cs_n     <= 1'b1;
      dac_sclk     <= 1'b0;
      dac_mosi     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_valid) begin
            shreg        <= sample_in ^ MSB_MASK;
            dac_mosi     <= sample_in[DATA_W-1] ^ MSB_MASK[DATA_W-1];
            dac_cs_n     <= 1'b0;
            sample_ready <= 1'b0;
            busy         <= 1'b1;
            cnt          <= DIV_LOAD;
            state        <= LEAD;
          end
        end

        LEAD: begin
          if (cnt == '0) begin
            dac_sclk <= 1'b1;
            cnt      <= DIV_LOAD;
            half     <= HALF_LOAD;
            state    <= SHIFT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // half counts remaining half-periods; odd values are the high phases
        SHIFT: begin
          if (cnt == '0) begin
            cnt <= DIV_LOAD;
            if (half == '0) begin
              state <= TRAIL;
            end else begin
              half     <= half - 1'b1;
              dac_sclk <= ~dac_sclk;
              if (dac_sclk && (half != HALF_ONE)) begin
                dac_mosi <= shreg[DATA_W-2];
                shreg    <= {shreg[DATA_W-2:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        TRAIL: begin
          if (cnt == '0) begin
            dac_cs_n <= 1'b1;
            dac_mosi <= 1'b0;
            cnt      <= GAP_LOAD;
            state    <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        GAP: begin
          if (cnt == '0) begin
            sample_ready <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          sample_ready <= 1'b1;
          busy         <= 1'b0;
          dac_cs_n     <= 1'b1;
          dac_sclk     <= 1'b0;
          dac_mosi     <= 1'b0;
        end
      endcase
    end
  end

  // a drop in the same cycle as overrun_clr restarts the count at one
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (overrun_clr)
        drop_count <= 8'd1;
      else if (drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end else if (overrun_clr) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (div 4, div 4 with MSB invert, div 1),
// a cycle-level timing/drop model and a frame monitor that decodes the SPI pins.

module tb_dac_spi_tx;

  localparam int W = 16;
  localparam int D_TAB  [3] = '{4, 4, 1};
  localparam int CS_TAB [3] = '{2, 2, 1};
  localparam int INV_TAB[3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] din [3];
  logic [2:0] vld, clr, rdy, bsy, csn, sck, mosi, ovr;
  logic [7:0] dcnt [3];

  always #5 clk = ~clk;

  dac_spi_tx #(.DATA_W(16), .CLK_DIV(4), .CS_IDLE(2), .MSB_INVERT(0)) u0 (
    .clk(clk), .reset(reset), .sample_in(din[0]), .sample_valid(vld[0]),
    .sample_ready(rdy[0]), .busy(bsy[0]), .dac_cs_n(csn[0]), .dac_sclk(sck[0]),
    .dac_mosi(mosi[0]), .overrun(ovr[0]), .overrun_clr(clr[0]), .drop_count(dcnt[0]));

  dac_spi_tx #(.DATA_W(16), .CLK_DIV(4), .CS_IDLE(2), .MSB_INVERT(1)) u1 (
    .clk(clk), .reset(reset), .sample_in(din[1]), .sample_valid(vld[1]),
    .sample_ready(rdy[1]), .busy(bsy[1]), .dac_cs_n(csn[1]), .dac_sclk(sck[1]),
    .dac_mosi(mosi[1]), .overrun(ovr[1]), .overrun_clr(clr[1]), .drop_count(dcnt[1]));

  dac_spi_tx #(.DATA_W(16), .CLK_DIV(1), .CS_IDLE(1), .MSB_INVERT(0)) u2 (
    .clk(clk), .reset(reset), .sample_in(din[2]), .sample_valid(vld[2]),
    .sample_ready(rdy[2]), .busy(bsy[2]), .dac_cs_n(csn[2]), .dac_sclk(sck[2]),
    .dac_mosi(mosi[2]), .overrun(ovr[2]), .overrun_clr(clr[2]), .drop_count(dcnt[2]));

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic        model_ok = 1'b0;
  int          edge_n = 0;
  logic        exp_rdy [3];
  int          ready_edge [3];
  logic        exp_ovr [3];
  int          exp_drops [3];
  logic [15:0] exp_word [3];
  logic        pend [3];
  logic        abort [3];

  // monitor state
  logic        in_frame [3];
  int          len [3], rises [3], chg [3], zeros [3];
  int          first_rise [3], last_rise [3], pmin [3], pmax [3];
  logic [15:0] word [3];
  logic        p_sck [3], p_mosi [3];
  int          last_len [3], last_rises [3], last_chg [3], last_zeros [3];
  int          last_pmin [3], last_pmax [3];
  logic [15:0] last_word [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_frame[i] = 1'b0; abort[i] = 1'b0; pend[i] = 1'b0;
      p_sck[i] = 1'b0; p_mosi[i] = 1'b0; rises[i] = 0;
    end
  end

  // model: readiness from accept time plus frame length, drop/overrun bookkeeping
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        exp_rdy[i] = 1'b1; exp_ovr[i] = 1'b0; exp_drops[i] = 0;
        pend[i] = 1'b0; abort[i] = 1'b1;
      end else begin
        logic idle;
        idle = exp_rdy[i];
        if (vld[i] && idle) begin
          check_val($sformatf("u%0d_frame_missing", i), {31'd0, pend[i]}, 0);
          exp_word[i] = din[i] ^ ((INV_TAB[i] != 0) ? 16'h8000 : 16'h0000);
          pend[i] = 1'b1;
          exp_rdy[i] = 1'b0;
          ready_edge[i] = edge_n + (2 * W + 2) * D_TAB[i] + CS_TAB[i];
        end else if (!idle && edge_n >= ready_edge[i]) begin
          exp_rdy[i] = 1'b1;
        end
        if (vld[i] && !idle) begin
          exp_ovr[i] = 1'b1;
          exp_drops[i] = clr[i] ? 1 : ((exp_drops[i] < 255) ? exp_drops[i] + 1 : 255);
        end else if (clr[i]) begin
          exp_ovr[i] = 1'b0;
          exp_drops[i] = 0;
        end
      end
    end
    if (reset) model_ok = 1'b1;
    edge_n++;
  end

  // monitor: decode frames from the pins and compare against the model
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (abort[i]) begin
        in_frame[i] = 1'b0;
        abort[i] = 1'b0;
      end else if (!csn[i]) begin
        if (!in_frame[i]) begin
          in_frame[i] = 1'b1; len[i] = 0; rises[i] = 0; word[i] = '0; chg[i] = 0;
          zeros[i] = 0; first_rise[i] = -1; last_rise[i] = -1; pmin[i] = 1000000; pmax[i] = 0;
        end else if (mosi[i] != p_mosi[i] && !(p_sck[i] && !sck[i])) begin
          chg[i]++;
        end
        if (sck[i] && !p_sck[i]) begin
          word[i] = {word[i][14:0], mosi[i]};
          if (last_rise[i] >= 0) begin
            if (len[i] - last_rise[i] < pmin[i]) pmin[i] = len[i] - last_rise[i];
            if (len[i] - last_rise[i] > pmax[i]) pmax[i] = len[i] - last_rise[i];
          end else begin
            first_rise[i] = len[i];
          end
          last_rise[i] = len[i];
          rises[i]++;
        end
        if (!mosi[i]) zeros[i]++;
        len[i]++;
      end else begin
        if (model_ok) begin
          check_val($sformatf("u%0d_idle_mosi", i), {31'd0, mosi[i]}, 0);
          check_val($sformatf("u%0d_idle_sclk", i), {31'd0, sck[i]}, 0);
        end
        if (in_frame[i]) begin
          in_frame[i] = 1'b0;
          last_len[i] = len[i]; last_rises[i] = rises[i]; last_word[i] = word[i];
          last_chg[i] = chg[i]; last_zeros[i] = zeros[i];
          last_pmin[i] = pmin[i]; last_pmax[i] = pmax[i];
          check_val($sformatf("u%0d_frame_expected", i), {31'd0, pend[i]}, 1);
          check_val($sformatf("u%0d_word", i), {16'd0, word[i]}, {16'd0, exp_word[i]});
          check_val($sformatf("u%0d_cs_low_len", i), len[i], (2 * W + 2) * D_TAB[i]);
          check_val($sformatf("u%0d_rises", i), rises[i], W);
          check_val($sformatf("u%0d_lead", i), first_rise[i], D_TAB[i]);
          check_val($sformatf("u%0d_period_min", i), pmin[i], 2 * D_TAB[i]);
          check_val($sformatf("u%0d_period_max", i), pmax[i], 2 * D_TAB[i]);
          check_val($sformatf("u%0d_mosi_glitch", i), chg[i], 0);
          pend[i] = 1'b0;
        end
      end
      if (model_ok) begin
        check_val($sformatf("u%0d_ready", i), {31'd0, rdy[i]}, {31'd0, exp_rdy[i]});
        check_val($sformatf("u%0d_busy", i), {31'd0, bsy[i]}, {31'd0, !exp_rdy[i]});
        check_val($sformatf("u%0d_overrun", i), {31'd0, ovr[i]}, {31'd0, exp_ovr[i]});
        check_val($sformatf("u%0d_drop_count", i), {24'd0, dcnt[i]}, exp_drops[i]);
      end
      p_sck[i] = sck[i];
      p_mosi[i] = mosi[i];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int i, input logic [15:0] d);
    din[i] = d;
    vld[i] = 1'b1;
    step();
    vld[i] = 1'b0;
  endtask

  task automatic clear(input int i);
    clr[i] = 1'b1;
    step();
    clr[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (!(rdy[i] && !in_frame[i]) && n < 2000) begin
      step();
      n++;
    end
    check_val($sformatf("u%0d_wait_idle_timeout", i), {31'd0, n < 2000}, 1);
  endtask

  task automatic wait_rises(input int i, input int k);
    int n = 0;
    while (!(in_frame[i] && rises[i] >= k) && n < 1000) begin
      step();
      n++;
    end
    check_val($sformatf("u%0d_wait_rises_timeout", i), {31'd0, n < 1000}, 1);
  endtask

  initial begin
    int n;
    int acc;
    vld = '0;
    clr = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    reset = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("u%0d_rst_cs_n", i), {31'd0, csn[i]}, 1);
      check_val($sformatf("u%0d_rst_sclk", i), {31'd0, sck[i]}, 0);
      check_val($sformatf("u%0d_rst_mosi", i), {31'd0, mosi[i]}, 0);
      check_val($sformatf("u%0d_rst_ready", i), {31'd0, rdy[i]}, 1);
      check_val($sformatf("u%0d_rst_busy", i), {31'd0, bsy[i]}, 0);
      check_val($sformatf("u%0d_rst_overrun", i), {31'd0, ovr[i]}, 0);
      check_val($sformatf("u%0d_rst_drops", i), {24'd0, dcnt[i]}, 0);
    end
    reset = 1'b0;
    step();

    // single frame, ready latency
    pulse(0, 16'hA5C3);
    n = 1;
    while (!rdy[0] && n < 400) begin
      step();
      n++;
    end
    check_val("t1_ready_latency", n, 139);
    wait_idle(0);
    check_val("t1_len", last_len[0], 136);
    check_val("t1_rises", last_rises[0], 16);
    check_val("t1_word", {16'd0, last_word[0]}, 32'hA5C3);

    // MSB inversion
    pulse(1, 16'h8000);
    wait_idle(1);
    check_val("t2_word_8000", {16'd0, last_word[1]}, 32'h0000);
    pulse(1, 16'h7FFF);
    wait_idle(1);
    check_val("t2_word_7fff", {16'd0, last_word[1]}, 32'hFFFF);

    // valid held high for 1000 cycles
    acc = 0;
    for (int c = 0; c < 1000; c++) begin
      din[0] = 16'($urandom);
      vld[0] = 1'b1;
      if (rdy[0]) acc++;
      step();
    end
    vld[0] = 1'b0;
    check_val("t3_accepts", acc, 8);
    check_val("t3_drops_sat", {24'd0, dcnt[0]}, 255);
    check_val("t3_overrun", {31'd0, ovr[0]}, 1);
    wait_idle(0);
    clear(0);
    check_val("t3_cleared", {24'd0, dcnt[0]}, 0);

    // drop mid-frame, clear, then drop/clear collision
    pulse(0, 16'h3C5A);
    wait_rises(0, 5);
    pulse(0, 16'h1111);
    check_val("t4_overrun_set", {31'd0, ovr[0]}, 1);
    check_val("t4_drop_one", {24'd0, dcnt[0]}, 1);
    clear(0);
    check_val("t4_overrun_clr", {31'd0, ovr[0]}, 0);
    pulse(0, 16'h2222);
    pulse(0, 16'h3333);
    check_val("t4_drop_two", {24'd0, dcnt[0]}, 2);
    din[0] = 16'h4444;
    vld[0] = 1'b1;
    clr[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    clr[0] = 1'b0;
    check_val("t4_collide_ovr", {31'd0, ovr[0]}, 1);
    check_val("t4_collide_cnt", {24'd0, dcnt[0]}, 1);
    clear(0);
    wait_idle(0);
    check_val("t4_word", {16'd0, last_word[0]}, 32'h3C5A);

    // reset at the 7th rising edge, then an immediate new frame
    pulse(0, 16'h1234);
    wait_rises(0, 3);
    pulse(0, 16'h5555);
    wait_rises(0, 7);
    reset = 1'b1;
    step();
    check_val("t5_cs_n", {31'd0, csn[0]}, 1);
    check_val("t5_sclk", {31'd0, sck[0]}, 0);
    check_val("t5_mosi", {31'd0, mosi[0]}, 0);
    check_val("t5_ready", {31'd0, rdy[0]}, 1);
    check_val("t5_drops", {24'd0, dcnt[0]}, 0);
    reset = 1'b0;
    pulse(0, 16'hBEEF);
    wait_idle(0);
    check_val("t5_word", {16'd0, last_word[0]}, 32'hBEEF);
    check_val("t5_len", last_len[0], 136);

    // CLK_DIV=1
    pulse(2, 16'hFFFF);
    wait_idle(2);
    check_val("t6_len", last_len[2], 34);
    check_val("t6_period_min", last_pmin[2], 2);
    check_val("t6_period_max", last_pmax[2], 2);
    check_val("t6_zeros", last_zeros[2], 0);
    check_val("t6_glitch", last_chg[2], 0);
    check_val("t6_word", {16'd0, last_word[2]}, 32'hFFFF);

    // random traffic on all instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        vld[i] = ($urandom_range(0, 39) == 0);
        clr[i] = ($urandom_range(0, 149) == 0);
        din[i] = 16'($urandom);
      end
      step();
    end
    vld = '0;
    clr = '0;
    for (int i = 0; i < 3; i++) wait_idle(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
